// File: rtl/horizontal_timing_generator.sv
// -----------------------------------------------------------------------------
// horizontal_timing_generator
//
// VGA horizontal timing for one scanline. A per-state counter, advanced only
// on pixel-enable cycles, walks a four-state machine in this order:
// FRONT_PORCH -> SYNC_PULSE -> BACK_PORCH -> ACTIVE_VIDEO -> FRONT_PORCH.
// The line_done strobe is the increment for the downstream vertical line
// counter.
//
// Optional feature macro: HTIMING_PIXEL_X_EN
//   defined   : pixel_x reports the active-video column (0..H_ACTIVE-1) while
//               in ACTIVE_VIDEO and 0 elsewhere.
//   undefined : pixel_x is tied to 0 and its decode is not built.
//
// Ports:
//   clk_i                     in  1      system clock
//   rst_i                     in  1      synchronous active-high reset
//   pixel_en_i                in  1      pixel-rate enable (timing advances
//                                        only when high)
//   restart_i                 in  1      synchronous line restart
//   hsync_o                   out 1      horizontal sync, active low
//   horizontal_active_video_o out 1      high during active video
//   pixel_x_o                 out CNT_W  active-video column
//   line_done_o               out 1      strobe on the last active pixel
//
// Enable semantics: pixel_en_i acts as the single "valid" qualifier for the
// timing stream. There is no backpressure: every cycle with pixel_en_i high
// consumes one pixel slot, cycles with it low consume nothing. rst_i beats
// restart_i, which beats pixel_en_i.
// -----------------------------------------------------------------------------
module horizontal_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int CNT_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pixel_en_i,
  input  logic             restart_i,
  output logic             hsync_o,
  output logic             horizontal_active_video_o,
  output logic [CNT_W-1:0] pixel_x_o,
  output logic             line_done_o
);

  typedef enum logic [1:0] {
    FRONT_PORCH  = 2'd0,
    SYNC_PULSE   = 2'd1,
    BACK_PORCH   = 2'd2,
    ACTIVE_VIDEO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(H_FRONT  - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(H_SYNC   - 1);
  localparam logic [CNT_W-1:0] LAST_BACK   = CNT_W'(H_BACK   - 1);
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(H_ACTIVE - 1);

  // state is kept as a plainly named signal so checkers can bind to it.
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] last_cnt;
  logic             state_last;

  // Terminal count of the current state.
  always_comb begin
    last_cnt = LAST_FRONT;
    unique case (state)
      FRONT_PORCH:  last_cnt = LAST_FRONT;
      SYNC_PULSE:   last_cnt = LAST_SYNC;
      BACK_PORCH:   last_cnt = LAST_BACK;
      ACTIVE_VIDEO: last_cnt = LAST_ACTIVE;
      default:      last_cnt = LAST_FRONT;
    endcase
  end

  assign state_last = (cnt == last_cnt);

  // Next-state / next-count. Reset is applied in the register process so it
  // dominates everything here.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (restart_i) begin
      state_next = FRONT_PORCH;
      cnt_next   = '0;
    end else if (pixel_en_i) begin
      if (state_last) begin
        cnt_next = '0;
        unique case (state)
          FRONT_PORCH:  state_next = SYNC_PULSE;
          SYNC_PULSE:   state_next = BACK_PORCH;
          BACK_PORCH:   state_next = ACTIVE_VIDEO;
          ACTIVE_VIDEO: state_next = FRONT_PORCH;
          default:      state_next = FRONT_PORCH;
        endcase
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FRONT_PORCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Moore outputs from the registered state.
  assign hsync_o                   = (state != SYNC_PULSE);
  assign horizontal_active_video_o = (state == ACTIVE_VIDEO);

  // Mealy strobe: same cycle as the final active enable, so the vertical
  // counter samples it on the very edge that wraps this line.
  assign line_done_o = (state == ACTIVE_VIDEO) && state_last && pixel_en_i &&
                       !restart_i && !rst_i;

`ifdef HTIMING_PIXEL_X_EN
  assign pixel_x_o = (state == ACTIVE_VIDEO) ? cnt : '0;
`else
  assign pixel_x_o = '0;
`endif

endmodule

// File: tb/tb_horizontal_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_horizontal_timing_generator
//
// Driver pushes one expected output word per clock into exp_q, computed from a
// line-position reference model (position 0..799 counted in enables since the
// last reset/restart). A monitor pops and compares every cycle. A few directed
// measurements (sync width, active width, line period) are checked against
// constants after the relevant phases.
// -----------------------------------------------------------------------------
module tb_horizontal_timing_generator;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int CNT_W    = 10;
  localparam int LINE     = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;
  localparam int SYNC_BEG = H_FRONT;
  localparam int SYNC_END = H_FRONT + H_SYNC;
  localparam int ACT_BEG  = H_FRONT + H_SYNC + H_BACK;
  localparam int W        = CNT_W + 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             pixel_en_i = 1'b0;
  logic             restart_i = 1'b0;
  logic             hsync_o;
  logic             horizontal_active_video_o;
  logic [CNT_W-1:0] pixel_x_o;
  logic             line_done_o;

  always #5 clk = ~clk;

  horizontal_timing_generator #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
    .H_BACK(H_BACK), .CNT_W(CNT_W)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst_i),
    .pixel_en_i                (pixel_en_i),
    .restart_i                 (restart_i),
    .hsync_o                   (hsync_o),
    .horizontal_active_video_o (horizontal_active_video_o),
    .pixel_x_o                 (pixel_x_o),
    .line_done_o               (line_done_o)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: position within the line, in enables
  int  pos = 0;
  bit  model_valid = 1'b0;

  // directed measurements, maintained by the monitor
  int cyc = 0;
  int sync_run = 0, last_sync_run = 0;
  int act_run = 0, last_act_run = 0;
  int last_ld_cyc = -1, ld_interval = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit rs, input bit en);
    logic             e_hs, e_av, e_ld;
    logic [CNT_W-1:0] e_px;
    @(negedge clk);
    rst_i      = r;
    restart_i  = rs;
    pixel_en_i = en;
    if (model_valid) begin
      e_hs = !(pos >= SYNC_BEG && pos < SYNC_END);
      e_av = (pos >= ACT_BEG);
`ifdef HTIMING_PIXEL_X_EN
      e_px = e_av ? CNT_W'(pos - ACT_BEG) : '0;
`else
      e_px = '0;
`endif
      e_ld = (pos == LINE - 1) && en && !rs && !r;
      exp_q.push_back({e_hs, e_av, e_px, e_ld});
    end
    if (r) begin
      pos = 0;
      model_valid = 1'b1;
    end else if (rs) pos = 0;
    else if (en)     pos = (pos + 1) % LINE;
  endtask

  task automatic run(input int n, input int en_mod);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, (i % en_mod) == en_mod - 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hsync",        int'(hsync_o),                   int'(e[W-1]));
        check("active_video", int'(horizontal_active_video_o), int'(e[W-2]));
        check("pixel_x",      int'(pixel_x_o),                 int'(e[CNT_W:1]));
        check("line_done",    int'(line_done_o),               int'(e[0]));
      end
      cyc++;
      if (!hsync_o) sync_run++;
      else if (sync_run != 0) begin last_sync_run = sync_run; sync_run = 0; end
      if (horizontal_active_video_o) act_run++;
      else if (act_run != 0) begin last_act_run = act_run; act_run = 0; end
      if (rst_i) last_ld_cyc = -1;
      else if (line_done_o) begin
        if (last_ld_cyc >= 0) ld_interval = cyc - last_ld_cyc;
        last_ld_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset, enable held high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);

    // full lines, enable constant high
    run(2 * LINE + 10, 1);
    check("sync_width",  last_sync_run, H_SYNC);
    check("active_width", last_act_run, H_ACTIVE);
    check("line_period_en1", ld_interval, LINE);

    // enable every 4th clock
    step(1'b1, 1'b0, 1'b1);
    ld_interval = 0;
    run(2 * 4 * LINE + 10, 4);
    check("line_period_en4", ld_interval, 4 * LINE);

    // restart mid-active (column 300)
    step(1'b1, 1'b0, 1'b1);
    run(ACT_BEG + 300, 1);
    step(1'b0, 1'b1, 1'b1);
    run(LINE + 50, 1);

    // restart held high for several cycles
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i[0]);
    run(200, 1);

    // restart coincident with the final active enable
    step(1'b1, 1'b0, 1'b1);
    run(LINE - 1, 1);
    step(1'b0, 1'b1, 1'b1);
    run(40, 1);

    // reset and restart together
    step(1'b1, 1'b1, 1'b1);
    run(LINE - 1, 1);
    step(1'b1, 1'b1, 1'b1);
    run(30, 1);

    // randomized enables, restarts and resets
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 699) == 0,
           $urandom_range(0, 3) != 0);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
